regression_stream_driver: RTL and testbench
===========================================

Name: regression_stream_driver

Overview:
- Host-side counterpart of the linear-regression core: buffers N (x,y) sample pairs written by a host, issues the core's `start`, and streams `inx`/`iny` into it.
- Captures the N residuals returned on `ei`/`out_ready` into a result buffer that the host reads back.
- Instantiated beside the regression core in the top level or system bench; all core-facing ports connect one-to-one.

Parameters:
- N_POINTS, 150, samples per run (1..2^ADDR_W).
- DATA_W, 20, width of x, y and ei.
- ADDR_W, 8, buffer address width.
- TIMEOUT, 4095, max cycles waited for `ready` or for each `out_ready` beat.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  host write strobe into sample buffer.
- wr_addr  in  ADDR_W  sample index.
- wr_x  in  DATA_W  sample x.
- wr_y  in  DATA_W  sample y.
- go  in  1  one-cycle pulse: begin a run.
- rd_addr  in  ADDR_W  result buffer read index.
- rd_data  out  DATA_W  result buffer word, combinational read.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse: run completed.
- timeout_err  out  1  sticky; set when a wait exceeds TIMEOUT.
- start  out  1  to core: one-cycle start pulse.
- inx  out  DATA_W  to core: x sample.
- iny  out  DATA_W  to core: y sample.
- ready  in  1  from core: loader idle, may accept start.
- out_ready  in  1  from core: ei valid this cycle.
- ei  in  DATA_W  from core: residual for the current point.

Behaviour:
- Reset values:
  - start, busy, done, timeout_err = 0.
  - inx, iny = 0.
  - FSM = IDLE; all counters = 0.
  - Buffers are not cleared.
- Host writes:
  - Accepted only in IDLE.
  - wr_en while busy is ignored.
  - wr_addr >= N_POINTS is ignored.
- FSM states:
  - IDLE:
    - `go` moves to WAIT_RDY, sets busy and clears timeout_err.
    - `go` while busy is ignored.
  - WAIT_RDY:
    - On ready=1, go to START.
    - Wait counter increments each cycle; if it passes TIMEOUT, set timeout_err and go to IDLE (busy=0, done not pulsed).
  - START:
    - start=1 for exactly one cycle.
    - inx/iny already present sample 0 in this cycle.
    - Then go to STREAM with index=1.
  - STREAM:
    - Each cycle presents buffer[index] on inx/iny and increments index.
    - The core samples one pair per cycle beginning the cycle start is high, N_POINTS pairs total.
    - After the cycle presenting sample N_POINTS-1, go to COLLECT with result index=0.
    - inx/iny hold the last sample afterwards.
  - COLLECT:
    - Each cycle with out_ready=1 writes ei to result[rindex] and increments rindex.
    - After N_POINTS beats, go to DONE.
    - The gap between beats (and before the first beat) is timed; exceeding TIMEOUT sets timeout_err and returns to IDLE.
    - out_ready pulses outside COLLECT are ignored.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency: start fires 1 cycle after ready is seen in WAIT_RDY; the last sample is driven N_POINTS-1 cycles after start.
- Simultaneous events:
  - `go` in the same cycle as wr_en in IDLE: the write completes, then the run starts.
  - out_ready on the final STREAM cycle is captured as beat 0, with the transition to COLLECT counted as already started.
- Reset mid-run: immediate abort; start drops asynchronously; the result buffer holds partial data.
- rd_addr >= N_POINTS returns 0.
- Counters are ADDR_W+1 bits wide, so N_POINTS = 2^ADDR_W does not wrap.

Optional Feature:
- Macro: RESIDUAL_ABS_SUM_EN.
- When defined:
  - Adds output `abs_sum` [DATA_W+ADDR_W-1:0], which accumulates |ei| (ei treated as two's complement) on each COLLECT beat.
  - abs_sum is cleared on `go`, held after DONE, and reset to 0.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Load x=i, y=2i+5 for i=0..149; pulse go with ready=1 -> start high 1 cycle; inx/iny = 0/5 at start, 149/303 after 149 more cycles; busy=1 throughout.
- Model out_ready burst of 150 beats, ei=i-75 -> rd_data(0)=-75 (0xFFFB5), rd_data(149)=74; done pulses once; busy=0.
- Hold ready=0 for 4100 cycles after go -> timeout_err=1 and busy=0 at cycle 4096; start never asserted; a subsequent go clears timeout_err.
- Assert reset during STREAM at index 60 -> start=0, busy=0, inx=0 immediately; a subsequent go runs a full 150-sample stream from index 0.
- wr_en to addr 10 while busy, and go while busy -> buffer[10] unchanged, no second run.
- With RESIDUAL_ABS_SUM_EN and ei=i-75 -> abs_sum=5625 at done.

Source files
------------

// File: rtl/regression_stream_driver.sv
`default_nettype none
// regression_stream_driver: buffers N (x,y) samples, drives the regression core and captures its residuals.
// Define RESIDUAL_ABS_SUM_EN to add the abs_sum residual-magnitude accumulator.  Rev 1.0
module regression_stream_driver #(
    parameter int N_POINTS = 150,
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_x,
    input  logic [DATA_W-1:0] wr_y,
    input  logic              go,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
`ifdef RESIDUAL_ABS_SUM_EN
    output logic [DATA_W+ADDR_W-1:0] abs_sum,
`endif
    output logic              start,
    output logic [DATA_W-1:0] inx,
    output logic [DATA_W-1:0] iny,
    input  logic              ready,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] ei
);

    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] NPTS = CW'(N_POINTS);
    localparam logic [CW-1:0] LAST = CW'(N_POINTS - 1);
    localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_START    = 3'd2,
        S_STREAM   = 3'd3,
        S_COLLECT  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     ridx_q, ridx_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0] inx_q, inx_d;
    logic [DATA_W-1:0] iny_q, iny_d;
    logic              tmo_q, tmo_d;

    logic              w_cap;
    logic              w_wr_ok;
    logic [CW-1:0]     w_idx_nx;

    logic [DATA_W-1:0] xbuf_q [N_POINTS];
    logic [DATA_W-1:0] ybuf_q [N_POINTS];
    logic [DATA_W-1:0] res_q  [N_POINTS];

    assign w_wr_ok  = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < NPTS);
    assign w_idx_nx = idx_q + CW'(1);

    // Sample and result storage survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            xbuf_q[wr_addr] <= wr_x;
            ybuf_q[wr_addr] <= wr_y;
        end
        if (w_cap) begin
            res_q[ridx_q[ADDR_W-1:0]] <= ei;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ridx_q  <= '0;
            wcnt_q  <= '0;
            inx_q   <= '0;
            iny_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ridx_q  <= ridx_d;
            wcnt_q  <= wcnt_d;
            inx_q   <= inx_d;
            iny_q   <= iny_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ridx_d  = ridx_q;
        wcnt_d  = wcnt_q;
        inx_d   = inx_q;
        iny_d   = iny_q;
        tmo_d   = tmo_q;
        w_cap   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_WAIT_RDY;
                    tmo_d   = 1'b0;
                    wcnt_d  = '0;
                    ridx_d  = '0;
                end
            end
            S_WAIT_RDY: begin
                if (ready) begin
                    state_d = S_START;
                    idx_d   = '0;
                    inx_d   = xbuf_q[0];
                    iny_d   = ybuf_q[0];
                end else if (wcnt_q == TMO) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_START, S_STREAM: begin
                if (idx_q == LAST) begin
                    // Final presented sample: a beat arriving now already counts as beat 0.
                    state_d = S_COLLECT;
                    wcnt_d  = '0;
                    if (out_ready) begin
                        w_cap  = 1'b1;
                        ridx_d = CW'(1);
                        if (LAST == '0) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    state_d = S_STREAM;
                    idx_d   = w_idx_nx;
                    inx_d   = xbuf_q[w_idx_nx[ADDR_W-1:0]];
                    iny_d   = ybuf_q[w_idx_nx[ADDR_W-1:0]];
                end
            end
            S_COLLECT: begin
                if (out_ready) begin
                    w_cap  = 1'b1;
                    ridx_d = ridx_q + CW'(1);
                    wcnt_d = '0;
                    if (ridx_q == LAST) begin
                        state_d = S_DONE;
                    end
                end else if (wcnt_q == TMO) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start       = (state_q == S_START);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_WAIT_RDY) || (state_q == S_START) ||
                         (state_q == S_STREAM)   || (state_q == S_COLLECT);
    assign timeout_err = tmo_q;
    assign inx         = inx_q;
    assign iny         = iny_q;
    assign rd_data     = ({1'b0, rd_addr} < NPTS) ? res_q[rd_addr] : '0;

`ifdef RESIDUAL_ABS_SUM_EN
    logic [DATA_W+ADDR_W-1:0] abs_sum_q;
    logic [DATA_W-1:0]        w_ei_mag;

    // The most negative residual maps to 2^(DATA_W-1), which still fits unsigned.
    assign w_ei_mag = ei[DATA_W-1] ? (-ei) : ei;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abs_sum_q <= '0;
        end else if ((state_q == S_IDLE) && go) begin
            abs_sum_q <= '0;
        end else if (w_cap) begin
            abs_sum_q <= abs_sum_q + {{ADDR_W{1'b0}}, w_ei_mag};
        end
    end

    assign abs_sum = abs_sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regression_stream_driver.sv
`default_nettype none
// tb_regression_stream_driver: randomized bench for regression_stream_driver against an array-based model.
// Rev 1.0
module tb_regression_stream_driver;

    localparam int N   = 150;
    localparam int DW  = 20;
    localparam int AW  = 8;
    localparam int TMO = 4095;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_x, wr_y;
    logic          go;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy, done, timeout_err, start;
    logic [DW-1:0] inx, iny;
    logic          ready, out_ready;
    logic [DW-1:0] ei;
`ifdef RESIDUAL_ABS_SUM_EN
    logic [DW+AW-1:0] abs_sum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mx  [N];
    logic [DW-1:0] my  [N];
    logic [DW-1:0] res [N];

    regression_stream_driver #(
        .N_POINTS(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .go(go), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .timeout_err(timeout_err),
`ifdef RESIDUAL_ABS_SUM_EN
        .abs_sum(abs_sum),
`endif
        .start(start), .inx(inx), .iny(iny),
        .ready(ready), .out_ready(out_ready), .ei(ei)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(i); wr_x = DW'(i); wr_y = DW'(2 * i + 5);
            mx[i] = DW'(i); my[i] = DW'(2 * i + 5);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_rand();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(i); wr_x = DW'($urandom); wr_y = DW'($urandom);
            mx[i] = wr_x; my[i] = wr_y;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One complete run: ready after rdly cycles, optional beat on the last stream cycle,
    // optional host intrusion while busy, optional host write in the go cycle.
    task automatic do_run(input int rdly, input bit early, input bit seq, input bit intrude, input bit gw);
        logic [DW-1:0] v;
        longint        asum;
        int            a, sv, gap;
        asum = 0;
        ready = 1'b0;
        @(negedge clk);
        go = 1'b1;
        if (gw) begin
            a = $urandom_range(N - 1, 0);
            wr_en = 1'b1; wr_addr = AW'(a); wr_x = DW'($urandom); wr_y = DW'($urandom);
            mx[a] = wr_x; my[a] = wr_y;
        end
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        chk("busy_after_go", busy, 1);
        chk("tmo_cleared", timeout_err, 0);
        repeat (rdly) @(negedge clk);
        chk("no_start_before_ready", start, 0);
        ready = 1'b1;
        @(negedge clk);
        chk("start_pulse", start, 1);
        chk("inx_s0", inx, mx[0]);
        chk("iny_s0", iny, my[0]);
        out_ready = 1'($urandom); ei = DW'($urandom);
        for (int k = 1; k < N; k++) begin
            @(negedge clk);
            chk("stream_x", inx, mx[k]);
            chk("stream_y", iny, my[k]);
            if (k == 1) chk("start_one_cycle", start, 0);
            if (k < N - 1) begin
                out_ready = 1'($urandom); ei = DW'($urandom);
            end else begin
                v = seq ? DW'(0 - 75) : DW'($urandom);
                out_ready = early; ei = v;
                if (early) begin
                    res[0] = v; sv = int'($signed(v)); asum += (sv < 0) ? -sv : sv;
                end
            end
        end
        @(negedge clk);
        chk("busy_collect", busy, 1);
        chk("inx_hold", inx, mx[N-1]);
        if (intrude) begin
            out_ready = 1'b0;
            wr_en = 1'b1; wr_addr = AW'(10); wr_x = DW'($urandom); wr_y = DW'($urandom); go = 1'b1;
            @(negedge clk);
            wr_en = 1'b0; go = 1'b0;
        end
        for (int b = (early ? 1 : 0); b < N; b++) begin
            gap = seq ? 0 : $urandom_range(3, 0);
            repeat (gap) begin
                out_ready = 1'b0; ei = DW'($urandom);
                @(negedge clk);
            end
            v = seq ? DW'(b - 75) : DW'($urandom);
            out_ready = 1'b1; ei = v; res[b] = v;
            sv = int'($signed(v)); asum += (sv < 0) ? -sv : sv;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
`ifdef RESIDUAL_ABS_SUM_EN
        chk("abs_sum", abs_sum, 64'(asum[DW+AW-1:0]));
`endif
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("iny_hold", iny, my[N-1]);
        if (intrude) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_second_run", busy | start, 0);
            end
        end
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i); #1;
            chk("rd_data", rd_data, res[i]);
        end
        rd_addr = AW'(N); #1;
        chk("rd_oob_n", rd_data, 0);
        rd_addr = '1; #1;
        chk("rd_oob_max", rd_data, 0);
    endtask

    task automatic abort_run(input int at);
        ready = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0; ready = 1'b1;
        @(negedge clk);
        repeat (at) @(negedge clk);
        chk("abort_pre_x", inx, mx[at]);
        if (at == 0) chk("abort_pre_start", start, 1);
        reset = 1'b1; #1;
        chk("abort_start", start, 0);
        chk("abort_busy", busy, 0);
        chk("abort_inx", inx, 0);
        chk("abort_iny", iny, 0);
        @(negedge clk);
        reset = 1'b0; ready = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        bit saw_start, saw_done;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; go = 1'b0;
        rd_addr = '0; ready = 1'b0; out_ready = 1'b0; ei = '0;
        repeat (3) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_inx", inx, 0);
        chk("rst_iny", iny, 0);
`ifdef RESIDUAL_ABS_SUM_EN
        chk("rst_abs_sum", abs_sum, 0);
`endif
        reset = 1'b0;

        load_ramp();
        do_run(0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_run($urandom_range(20, 1), 1'b1, 1'b0, 1'b1, 1'b0);

        // ready never comes: busy must last exactly TIMEOUT+1 cycles
        ready = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cnt = 0; saw_start = 0; saw_done = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            if (start) saw_start = 1;
            if (done) saw_done = 1;
            @(negedge clk);
        end
        chk("tmo_busy_cycles", cnt, TMO + 1);
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_no_start", saw_start, 0);
        chk("tmo_no_done", saw_done | done, 0);

        do_run(2, 1'b0, 1'b0, 1'b0, 1'b1);
        abort_run(0);
        abort_run(60);
        do_run(0, 1'b1, 1'b1, 1'b0, 1'b0);

        load_rand();
        for (int r = 0; r < 3; r++) begin
            do_run($urandom_range(10, 0), 1'(r), 1'b0, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
